// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared types and constants for the UART receiver slice.
//   - rx_state_t     : frame controller states
//   - PAR_EVEN/ODD   : encoding of the par_typ input
//   - START_IDX      : bit_count value of the start bit
//   - DATA_LAST_IDX  : bit_count value of the last data bit (8-bit frames)
//   - majority3      : 2-of-3 vote used by the sampler
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [3:0] START_IDX     = 4'd0;
  localparam logic [3:0] DATA_LAST_IDX = 4'd8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Captures rx_in at edge_count mid-1, mid and mid+1 (mid = prescale/2) and
//   registers the 2-of-3 majority vote as sampled_bit.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     enable       : sampling allowed (the frame counter is running)
//     rx_in        : synchronised serial input
//     edge_count   : oversampling position within the current bit
//     prescale     : oversampling ratio
//     sampled_bit  : voted bit value, valid from the cycle after mid+1
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] edge_count,
  input  logic [PRESC_W-1:0] prescale,
  output logic               sampled_bit
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] mid;
  logic [2:0]         taps;

  assign mid = prescale >> 1;

  // The third tap is voted directly from rx_in on the mid+1 edge, so the
  // result lands in sampled_bit one cycle after mid+1, long before bit_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      taps        <= 3'b000;
      sampled_bit <= 1'b0;
    end else if (enable) begin
      if (edge_count == mid - ONE) taps[0] <= rx_in;
      if (edge_count == mid)       taps[1] <= rx_in;
      if (edge_count == mid + ONE) begin
        taps[2]     <= rx_in;
        sampled_bit <= majority3(taps[0], taps[1], rx_in);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   UART receive frame controller. Drives the external edge/bit counter,
//   deserialises DATA_W bits LSB first, checks start, optional parity and
//   stop, and reports each frame with exactly one single-cycle pulse.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     rx_in        : synchronised serial input, idle high
//     prescale     : oversampling ratio (8, 16 or 32)
//     par_en       : frame carries a parity bit
//     par_typ      : 0 even parity, 1 odd parity
//     edge_count   : counter position within the bit
//     bit_count    : counter bit index within the frame (0 = start)
//     cnt_enable   : counter enable, high whenever a frame is in progress
//     p_data       : last good byte, held until the next good frame
//     data_valid   : pulse, good frame, p_data valid in the same cycle
//     par_err      : pulse, parity mismatch, frame dropped
//     stp_err      : pulse, stop bit low, frame dropped
//     strt_glitch  : pulse, start bit voted high, frame aborted
//     busy         : a frame is in progress
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic [PRESC_W-1:0] edge_count,
  input  logic [3:0]         bit_count,
  output logic               cnt_enable,
  output logic [DATA_W-1:0]  p_data,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               strt_glitch,
  output logic               busy
);

  localparam logic [PRESC_W-1:0] ONE      = PRESC_W'(1);
  localparam logic [3:0]         LAST_IDX = 4'(DATA_W);

  rx_state_t         state, state_next;
  logic [DATA_W-1:0] shift, shift_next;
  logic [DATA_W-1:0] p_data_next;
  logic              par_err_q, par_err_next;
  logic              dv_next, pe_next, se_next, sg_next;
  logic              sampled_bit;
  logic              bit_end;

  assign cnt_enable = (state != IDLE);
  assign busy       = (state != IDLE);
  assign bit_end    = cnt_enable && (edge_count == prescale - ONE);

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .enable      (cnt_enable),
    .rx_in       (rx_in),
    .edge_count  (edge_count),
    .prescale    (prescale),
    .sampled_bit (sampled_bit)
  );

  // State, datapath and output registers. Pulses are recomputed every
  // cycle so each one is high for a single cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      p_data      <= '0;
      par_err_q   <= 1'b0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      state       <= state_next;
      shift       <= shift_next;
      p_data      <= p_data_next;
      par_err_q   <= par_err_next;
      data_valid  <= dv_next;
      par_err     <= pe_next;
      stp_err     <= se_next;
      strt_glitch <= sg_next;
    end
  end

  // Frame sequencing. Every decision is taken on bit_end, when the voted
  // sample of the current bit has been stable for several cycles. The stop
  // check outranks the parity check so a frame yields at most one pulse.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    p_data_next  = p_data;
    par_err_next = par_err_q;
    dv_next      = 1'b0;
    pe_next      = 1'b0;
    se_next      = 1'b0;
    sg_next      = 1'b0;
    case (state)
      IDLE: begin
        par_err_next = 1'b0;
        if (!rx_in) state_next = START;
      end
      START: begin
        if (bit_end) begin
          if (sampled_bit) begin
            state_next = IDLE;
            sg_next    = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {sampled_bit, shift[DATA_W-1:1]};
          if (bit_count == LAST_IDX) state_next = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_err_next = ((^shift) ^ (par_typ == PAR_ODD)) != sampled_bit;
          state_next   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          if (!sampled_bit) begin
            se_next = 1'b1;
          end else if (par_err_q) begin
            pe_next = 1'b1;
          end else begin
            dv_next     = 1'b1;
            p_data_next = shift;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Self-checking bench for uart_rx_ctrl. Models the external edge/bit
//   counter, drives serial frames, and queues the expected pulse (kind,
//   p_data, cycle) for a monitor that checks every pulse the DUT emits.
module tb_uart_rx_ctrl;

  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;

  localparam logic [3:0] K_DV = 4'b1000;
  localparam logic [3:0] K_PE = 4'b0100;
  localparam logic [3:0] K_SE = 4'b0010;
  localparam logic [3:0] K_SG = 4'b0001;

  logic               clk = 1'b0;
  logic               rst;
  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               par_typ;
  logic [PRESC_W-1:0] edge_count;
  logic [3:0]         bit_count;
  logic               cnt_enable;
  logic [DATA_W-1:0]  p_data;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;
  logic               strt_glitch;
  logic               busy;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] model_pdata;

  uart_rx_ctrl #(
    .DATA_W  (DATA_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .edge_count  (edge_count),
    .bit_count   (bit_count),
    .cnt_enable  (cnt_enable),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: at the falling edge it names the cycle that just began.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural edge/bit counter: cleared while disabled, edge wraps at
  // prescale-1 and advances the bit index.
  always @(posedge clk) begin
    if (rst || !cnt_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count == prescale - 6'd1) begin
      edge_count <= '0;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if ({data_valid, par_err, stp_err, strt_glitch} != 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse actual=%b required=none cycle=%0d",
                 {data_valid, par_err, stp_err, strt_glitch}, cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_kind", {28'b0, data_valid, par_err, stp_err, strt_glitch},
                    {28'b0, mon_e.kind});
        checkOutput("p_data", {24'b0, p_data}, {24'b0, mon_e.data});
        checkOutput("pulse_cycle", cyc, mon_e.cycle);
      end
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting in the current cycle. 'late' is the extra
  // cycle the DUT needs when the start edge lands during its last STOP
  // cycle. noise_bit selects a line bit (0 = start) that gets a one-cycle
  // flip exactly on the DUT's mid sample.
  task automatic applyStimulus(input logic [7:0] data, input logic use_par,
                               input logic ptyp, input logic flip_par,
                               input logic stop_v, input int noise_bit,
                               input int late);
    logic bits [0:10];
    int   nb;
    int   p;
    int   mid;
    exp_t e;
    p   = int'(prescale);
    mid = p / 2;
    nb  = use_par ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    bits[9]    = (^data) ^ ptyp ^ flip_par;
    bits[nb-1] = stop_v;
    e.data  = model_pdata;
    e.cycle = cyc + late + 1 + p * nb;
    if (!stop_v) begin
      e.kind = K_SE;
    end else if (use_par && flip_par) begin
      e.kind = K_PE;
    end else begin
      e.kind      = K_DV;
      e.data      = data;
      model_pdata = data;
    end
    sb.push_back(e);
    par_en  = use_par;
    par_typ = ptyp;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < p; j++) begin
        rx_in = (k == noise_bit && j == late + 1 + mid) ? ~bits[k] : bits[k];
        @(posedge clk);
        #1;
      end
    end
    rx_in = 1'b1;
  endtask

  // Start bit only 3 cycles long: the vote sees a high start bit.
  task automatic applyGlitch();
    exp_t e;
    e.kind  = K_SG;
    e.data  = model_pdata;
    e.cycle = cyc + 1 + int'(prescale);
    sb.push_back(e);
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
  endtask

  initial begin
    rst         = 1'b1;
    rx_in       = 1'b1;
    par_en      = 1'b0;
    par_typ     = 1'b0;
    prescale    = 6'd8;
    model_pdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_cnt_enable", {31'b0, cnt_enable}, 32'd0);
    checkOutput("reset_p_data", {24'b0, p_data}, 32'd0);
    checkOutput("reset_pulses", {28'b0, data_valid, par_err, stp_err, strt_glitch}, 32'd0);
    idle(4);

    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(20);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(20);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);
    idle(20);
    applyStimulus(8'h5B, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    idle(20);
    applyStimulus(8'h5B, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
    idle(20);
    applyGlitch();
    idle(20);
    checkOutput("glitch_idle_busy", {31'b0, busy}, 32'd0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    idle(20);
    applyStimulus(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0);
    idle(20);
    applyStimulus(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    idle(20);

    prescale = 6'd16;
    idle(4);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    applyStimulus(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1);
    idle(40);

    // Reset in the middle of the data bits: no pulse may follow.
    rx_in = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
    rst   = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_pdata = 8'h00;
    checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset_cnt_enable", {31'b0, cnt_enable}, 32'd0);
    checkOutput("midreset_p_data", {24'b0, p_data}, 32'd0);
    idle(200);
    applyStimulus(8'h42, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    idle(40);

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
